flash_cp_sequencer: RTL and testbench
=====================================

Name: flash_cp_sequencer

Overview:
Sequences the flash high-voltage charge pump that drives the VCPHV node and its capacitance macro. On a request it enables the pump and waits for the voltage-OK comparator to settle. It then holds the rail, and on release or fault it runs a timed discharge. It sits between the flash program/erase controller and the analog pump/discharge enables.

Parameters:
CNT_W, 12, width of the ramp and discharge counters.
SETTLE_CYC, 16, consecutive synced vok cycles required to declare the rail ready (2..2^CNT_W-1).
RAMP_TMO, 2048, maximum cycles allowed in RAMP before a timeout error (greater than SETTLE_CYC, at most 2^CNT_W-1).
DISCH_CYC, 64, cycles disch_en is held asserted (1..2^CNT_W-1).
DROP_FILT, 4, consecutive synced vok-low cycles in READY that count as a rail drop (at least 1).

Ports:
CLK  in  1  system clock
RESETB  in  1  asynchronous active-low reset
req  in  1  level request for high voltage from the program/erase controller
vok  in  1  asynchronous voltage-OK comparator output from the analog block
clr_err  in  1  single-cycle pulse that clears the ERROR state
cp_en  out  1  charge pump enable
disch_en  out  1  VCPHV discharge switch enable
ready  out  1  rail is stable and usable
busy  out  1  the sequencer is not in IDLE
done  out  1  one-cycle pulse when a discharge completes normally
err  out  1  sticky fault indication
err_code  out  2  fault cause: 0 none, 1 ramp timeout, 2 rail drop
state  out  3  current state, for debug

Behaviour:
- Reset: RESETB low asynchronously forces IDLE. All outputs go to 0, and all counters, flags and sync flops clear. A reset during any state drops cp_en immediately and performs no discharge.
- vok passes through a 2-flop synchronizer to give vok_s. All vok decisions use vok_s.
- Encodings: IDLE 0, RAMP 1, READY 2, DISCH 3, ERROR 4. All outputs are registered and update on the same edge as the state register.
- IDLE: cp_en=0, disch_en=0, busy=0.
  - req=1 sampled at an edge moves to RAMP on that edge, with cp_en=1 and busy=1 from that edge.
  - Counters clear.
- RAMP: cp_en=1.
  - ramp_cnt increments on every edge.
  - settle_cnt increments on edges with vok_s=1 and clears on edges with vok_s=0.
  - Priority 1: req=0 moves to DISCH (abort, no error).
  - Priority 2: vok_s=1 with settle_cnt==SETTLE_CYC-1 moves to READY, with ready=1 on that edge.
  - Priority 3: ramp_cnt==RAMP_TMO-1 moves to DISCH with a pending error, err_code=1.
  - If settle and timeout occur on the same edge, settle wins.
- READY: cp_en=1, ready=1.
  - drop_cnt counts consecutive vok_s=0 cycles.
  - drop_cnt reaching DROP_FILT-1 with vok_s=0 moves to DISCH with a pending error, err_code=2. This has priority over req=0.
  - Otherwise req=0 moves to DISCH.
- DISCH: cp_en=0, disch_en=1, ready=0.
  - The counter runs DISCH_CYC edges, so disch_en is high for exactly DISCH_CYC cycles.
  - On the final edge with no pending error: go to IDLE and pulse done=1 for one cycle.
  - On the final edge with a pending error: go to ERROR with err=1; done is not pulsed.
  - req is ignored in DISCH; discharge always completes.
  - If req is still 1 in IDLE, RAMP restarts on the next edge. The minimum gap with cp_en=0 is DISCH_CYC+1 cycles.
- ERROR: cp_en=0, disch_en=0, err=1, busy=1, err_code held.
  - Leaves to IDLE only on an edge with clr_err=1 and req=0. That edge clears err and err_code.
  - clr_err while req=1 is ignored.
- cp_en and disch_en are never 1 in the same cycle.
- ready=1 implies cp_en=1.

Test Plan:
All scenarios use SETTLE_CYC=4, RAMP_TMO=32, DISCH_CYC=8, DROP_FILT=3.
- Normal cycle: req=1 at cycle 0 gives cp_en=1 at edge 1. vok=1 from cycle 5 gives ready=1 four edges after vok_s rises (edge 10). req=0 at cycle 20 gives disch_en=1 for exactly 8 cycles, then done one-cycle pulse, IDLE, err=0.
- Ramp timeout: req=1 with vok held 0 gives cp_en=1 for 32 cycles, then disch_en for 8 cycles, then ERROR with err=1, err_code=1. clr_err with req=1 keeps ERROR; clr_err with req=0 returns to IDLE with err=0.
- Rail drop and glitch filter: in READY, a 2-cycle vok low causes no change. A 3-cycle vok_s low causes DISCH, then ERROR with err_code=2; ready falls on the transition edge.
- Abort and settle reset: a vok glitch low at settle_cnt=2 restarts settling. req=0 during RAMP gives DISCH for 8 cycles and done=1 with no error. req reasserted during DISCH gives RAMP one cycle after IDLE.
- Async reset mid-READY: RESETB low between edges gives cp_en, ready and busy at 0 immediately with state=0. After release, req=1 restarts from RAMP.
- Invariants: cp_en and disch_en are never both 1, and ready=1 implies cp_en=1, checked across randomized req/vok/clr_err sequences.

Source files
------------

// File: rtl/flash_cp_sequencer.sv
// ---------------------------------------------------------------------------
// flash_cp_sequencer
//   Sequences the flash high-voltage charge pump that drives VCPHV.
//   A request enables the pump (RAMP) and waits for the synchronized
//   voltage-OK comparator to stay high for SETTLE_CYC cycles (READY).
//   Release of the request or a filtered rail drop runs a timed discharge
//   (DISCH). A ramp timeout or rail drop finishes the discharge in a sticky
//   ERROR state that only clr_err with req low can leave.
//
// Ports
//   CLK       in   system clock
//   RESETB    in   asynchronous active-low reset
//   req       in   level request for high voltage
//   vok       in   asynchronous voltage-OK comparator (synchronized here)
//   clr_err   in   single-cycle pulse clearing ERROR (only when req=0)
//   cp_en     out  charge pump enable
//   disch_en  out  VCPHV discharge switch enable
//   ready     out  rail stable and usable
//   busy      out  sequencer not in IDLE
//   done      out  one-cycle pulse on normal discharge completion
//   err       out  sticky fault indication
//   err_code  out  0 none, 1 ramp timeout, 2 rail drop
//   state     out  current state (IDLE 0, RAMP 1, READY 2, DISCH 3, ERROR 4)
// ---------------------------------------------------------------------------
module flash_cp_sequencer #(
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 16,
  parameter int RAMP_TMO   = 2048,
  parameter int DISCH_CYC  = 64,
  parameter int DROP_FILT  = 4
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       req,
  input  logic       vok,
  input  logic       clr_err,
  output logic       cp_en,
  output logic       disch_en,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_READY = 3'd2,
    S_DISCH = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  // Terminal counts: each counter compares against its last value so the
  // transition lands on the edge that completes the required count.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RAMP_TMO - 1);
  localparam logic [CNT_W-1:0] DISCH_LAST  = CNT_W'(DISCH_CYC - 1);
  localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_FILT - 1);

  state_t           r_state;
  logic             r_vok_m;
  logic             r_vok_s;
  logic [CNT_W-1:0] r_ramp_cnt;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_disch_cnt;
  logic             r_pend_err;

  logic w_settled;
  logic w_timeout;
  logic w_drop_hit;
  logic w_disch_last;

  assign w_settled    = r_vok_s && (r_settle_cnt == SETTLE_LAST);
  assign w_timeout    = (r_ramp_cnt == TMO_LAST);
  assign w_drop_hit   = !r_vok_s && (r_drop_cnt == DROP_LAST);
  assign w_disch_last = (r_disch_cnt == DISCH_LAST);

  assign state = r_state;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state      <= S_IDLE;
      r_vok_m      <= 1'b0;
      r_vok_s      <= 1'b0;
      r_ramp_cnt   <= '0;
      r_settle_cnt <= '0;
      r_drop_cnt   <= '0;
      r_disch_cnt  <= '0;
      r_pend_err   <= 1'b0;
      cp_en        <= 1'b0;
      disch_en     <= 1'b0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      // Two-flop synchronizer for the analog comparator.
      r_vok_m <= vok;
      r_vok_s <= r_vok_m;
      done    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_ramp_cnt   <= '0;
          r_settle_cnt <= '0;
          r_drop_cnt   <= '0;
          r_disch_cnt  <= '0;
          r_pend_err   <= 1'b0;
          if (req) begin
            r_state <= S_RAMP;
            cp_en   <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_RAMP: begin
          r_ramp_cnt   <= r_ramp_cnt + 1'b1;
          r_settle_cnt <= r_vok_s ? r_settle_cnt + 1'b1 : '0;
          if (!req) begin
            // Abort: discharge without flagging a fault.
            r_state     <= S_DISCH;
            cp_en       <= 1'b0;
            disch_en    <= 1'b1;
            r_disch_cnt <= '0;
            r_pend_err  <= 1'b0;
          end else if (w_settled) begin
            // Settle is checked before timeout so a same-edge tie succeeds.
            r_state    <= S_READY;
            ready      <= 1'b1;
            r_drop_cnt <= '0;
          end else if (w_timeout) begin
            r_state     <= S_DISCH;
            cp_en       <= 1'b0;
            disch_en    <= 1'b1;
            r_disch_cnt <= '0;
            r_pend_err  <= 1'b1;
            err_code    <= 2'd1;
          end
        end

        S_READY: begin
          // Consecutive low samples only; any high sample restarts the filter.
          r_drop_cnt <= r_vok_s ? '0 : r_drop_cnt + 1'b1;
          if (w_drop_hit) begin
            r_state     <= S_DISCH;
            cp_en       <= 1'b0;
            disch_en    <= 1'b1;
            ready       <= 1'b0;
            r_disch_cnt <= '0;
            r_pend_err  <= 1'b1;
            err_code    <= 2'd2;
          end else if (!req) begin
            r_state     <= S_DISCH;
            cp_en       <= 1'b0;
            disch_en    <= 1'b1;
            ready       <= 1'b0;
            r_disch_cnt <= '0;
            r_pend_err  <= 1'b0;
          end
        end

        S_DISCH: begin
          // req is deliberately ignored: a started discharge always completes.
          if (w_disch_last) begin
            disch_en <= 1'b0;
            if (r_pend_err) begin
              r_state <= S_ERROR;
              err     <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            r_disch_cnt <= r_disch_cnt + 1'b1;
          end
        end

        S_ERROR: begin
          // Clearing while high voltage is still requested would re-ramp
          // straight into the same fault, so req must be low too.
          if (clr_err && !req) begin
            r_state    <= S_IDLE;
            err        <= 1'b0;
            err_code   <= 2'd0;
            busy       <= 1'b0;
            r_pend_err <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          cp_en    <= 1'b0;
          disch_en <= 1'b0;
          ready    <= 1'b0;
          busy     <= 1'b0;
          err      <= 1'b0;
          err_code <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cp_sequencer.sv
// Testbench for flash_cp_sequencer. A behavioural model tracks the phase,
// the edge at which it was entered, and the history of sampled vok values;
// transitions are decided from run lengths over that history.
module tb_flash_cp_sequencer;
  localparam int CNT_W      = 12;
  localparam int SETTLE_CYC = 4;
  localparam int RAMP_TMO   = 32;
  localparam int DISCH_CYC  = 8;
  localparam int DROP_FILT  = 3;

  logic       CLK, RESETB, req, vok, clr_err;
  logic       cp_en, disch_en, ready, busy, done, err;
  logic [1:0] err_code;
  logic [2:0] state;
  logic [8:0] dut_vec;

  assign dut_vec = {cp_en, disch_en, ready, busy, done, err, state};

  flash_cp_sequencer #(
    .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .RAMP_TMO(RAMP_TMO),
    .DISCH_CYC(DISCH_CYC), .DROP_FILT(DROP_FILT)
  ) dut (
    .CLK(CLK), .RESETB(RESETB), .req(req), .vok(vok), .clr_err(clr_err),
    .cp_en(cp_en), .disch_en(disch_en), .ready(ready), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 ramp, 2 ready, 3 discharge, 4 error
  int mp, m_entry, m_cause;
  bit m_pend, m_done;
  bit vsamp[$];   // vok as sampled at each edge since reset release

  // vok as seen by decisions at edge j: the sample taken two edges earlier.
  function automatic bit vs_at(int j);
    return (j >= 2) ? vsamp[j-2] : 1'b0;
  endfunction

  task automatic model_reset();
    mp = 0; m_entry = 0; m_cause = 0; m_pend = 0; m_done = 0;
    vsamp.delete();
  endtask

  task automatic model_edge(input bit r, input bit v, input bit c);
    int k, n, run;
    k = vsamp.size();
    n = k - m_entry;
    m_done = 0;
    case (mp)
      0: if (r) begin mp = 1; m_entry = k; end
      1: begin
        run = 0;
        for (int j = k; j > m_entry && run < SETTLE_CYC && vs_at(j); j--) run++;
        if (!r) begin mp = 3; m_pend = 0; m_entry = k; end
        else if (run >= SETTLE_CYC) begin mp = 2; m_entry = k; end
        else if (n == RAMP_TMO) begin mp = 3; m_pend = 1; m_cause = 1; m_entry = k; end
      end
      2: begin
        run = 0;
        for (int j = k; j > m_entry && run < DROP_FILT && !vs_at(j); j--) run++;
        if (run >= DROP_FILT) begin mp = 3; m_pend = 1; m_cause = 2; m_entry = k; end
        else if (!r) begin mp = 3; m_pend = 0; m_entry = k; end
      end
      3: if (n == DISCH_CYC) begin
        if (m_pend) mp = 4;
        else begin mp = 0; m_done = 1; end
        m_entry = k;
      end
      4: if (c && !r) begin mp = 0; m_cause = 0; m_pend = 0; m_entry = k; end
      default: mp = 0;
    endcase
    vsamp.push_back(v);
  endtask

  function automatic logic [8:0] exp_vec();
    logic [2:0] s;
    s = 3'(mp);
    return {(mp == 1 || mp == 2), (mp == 3), (mp == 2), (mp != 0),
            m_done, (mp == 4), s};
  endfunction

  function automatic logic [1:0] exp_code();
    return (mp == 4) ? 2'(m_cause) : 2'd0;
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    model_edge(req, vok, clr_err);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESETB = 1'b0; req = 0; vok = 0; clr_err = 0;
    model_reset();
    #12;
    checks++;
    if ({dut_vec, err_code} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {dut_vec, err_code});
    end
    @(negedge CLK);
    RESETB = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle got=%b want=%b", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_normal();
    int rdy_edge = -1, dis_n = 0, done_n = 0;
    for (int e = 1; e <= 32; e++) begin
      req = (e <= 20); vok = (e >= 5);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL normal_outs edge=%0d got=%b want=%b", e, dut_vec, exp_vec());
      end
      if (e == 1) begin
        checks++;
        if (cp_en !== 1'b1) begin
          failures++;
          $display("FAIL normal_cp_first got=%b want=1", cp_en);
        end
      end
      if (ready === 1'b1 && rdy_edge < 0) rdy_edge = e;
      if (disch_en === 1'b1) dis_n++;
      if (done === 1'b1) done_n++;
    end
    checks++;
    if (rdy_edge != 10) begin
      failures++;
      $display("FAIL normal_ready_edge got=%0d want=10", rdy_edge);
    end
    checks++;
    if (dis_n != DISCH_CYC || done_n != 1) begin
      failures++;
      $display("FAIL normal_disch_done got=%0d/%0d want=%0d/1", dis_n, done_n, DISCH_CYC);
    end
    checks++;
    if (state !== 3'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL normal_end got=%0d/%b want=0/0", state, err);
    end
  endtask

  task automatic test_ramp_timeout();
    int cp_n = 0, dis_n = 0;
    req = 1; vok = 0;
    for (int e = 1; e <= 60 && state !== 3'd4; e++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL tmo_outs edge=%0d got=%b want=%b", e, dut_vec, exp_vec());
      end
      if (cp_en === 1'b1) cp_n++;
      if (disch_en === 1'b1) dis_n++;
    end
    checks++;
    if (cp_n != RAMP_TMO || dis_n != DISCH_CYC) begin
      failures++;
      $display("FAIL tmo_lengths got=%0d/%0d want=%0d/%0d", cp_n, dis_n, RAMP_TMO, DISCH_CYC);
    end
    checks++;
    if (state !== 3'd4 || err !== 1'b1 || err_code !== 2'd1) begin
      failures++;
      $display("FAIL tmo_error got=%0d/%b/%0d want=4/1/1", state, err, err_code);
    end
    clr_err = 1;
    step();
    checks++;
    if (state !== 3'd4 || err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_clr_held got=%0d/%b want=4/1", state, err);
    end
    req = 0;
    step();
    clr_err = 0;
    checks++;
    if (state !== 3'd0 || err !== 1'b0 || err_code !== 2'd0) begin
      failures++;
      $display("FAIL tmo_clr got=%0d/%b/%0d want=0/0/0", state, err, err_code);
    end
  endtask

  task automatic test_rail_drop();
    int fall_i = -1, low_ready = 0;
    req = 0; vok = 0;
    step(); step();
    req = 1; vok = 1;
    for (int i = 0; i < 20 && ready !== 1'b1; i++) step();
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_reach_ready got=%b want=1", ready);
    end
    vok = 0; step(); step(); vok = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drop_glitch_outs got=%b want=%b", dut_vec, exp_vec());
      end
      if (ready !== 1'b1) low_ready++;
    end
    checks++;
    if (low_ready != 0) begin
      failures++;
      $display("FAIL drop_glitch_filter got=%0d want=0", low_ready);
    end
    vok = 0;
    for (int i = 1; i <= 10 && fall_i < 0; i++) begin
      step();
      if (ready !== 1'b1) begin
        fall_i = i;
        checks++;
        if (disch_en !== 1'b1 || cp_en !== 1'b0) begin
          failures++;
          $display("FAIL drop_transition got=%b/%b want=1/0", disch_en, cp_en);
        end
      end
    end
    checks++;
    if (fall_i != 5) begin
      failures++;
      $display("FAIL drop_fall_edge got=%0d want=5", fall_i);
    end
    for (int i = 0; i < 15 && state !== 3'd4; i++) step();
    checks++;
    if (state !== 3'd4 || err !== 1'b1 || err_code !== 2'd2) begin
      failures++;
      $display("FAIL drop_error got=%0d/%b/%0d want=4/1/2", state, err, err_code);
    end
    req = 0; clr_err = 1;
    step();
    clr_err = 0;
    checks++;
    if (dut_vec !== exp_vec() || state !== 3'd0) begin
      failures++;
      $display("FAIL drop_clear got=%b want=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_abort();
    int rdy_edge = -1, dis_n = 0, done_i = -1, ramp_i = -1;
    req = 0; vok = 0;
    step(); step();
    for (int e = 1; e <= 12; e++) begin
      req = 1; vok = (e != 3);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL abort_settle_outs edge=%0d got=%b want=%b", e, dut_vec, exp_vec());
      end
      if (ready === 1'b1 && rdy_edge < 0) rdy_edge = e;
    end
    checks++;
    if (rdy_edge != 9) begin
      failures++;
      $display("FAIL abort_settle_restart got=%0d want=9", rdy_edge);
    end
    req = 0;
    for (int i = 0; i < 10; i++) step();
    req = 1; vok = 0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i <= 14; i++) begin
      req = (i >= 3);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL abort_outs i=%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
      if (disch_en === 1'b1) dis_n++;
      if (done === 1'b1) begin
        done_i = i;
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL abort_no_err got=%b want=0", err);
        end
      end
      if (done_i >= 0 && ramp_i < 0 && state === 3'd1) ramp_i = i;
    end
    checks++;
    if (dis_n != DISCH_CYC || done_i != DISCH_CYC || ramp_i != done_i + 1) begin
      failures++;
      $display("FAIL abort_timing got=%0d/%0d/%0d want=%0d/%0d/%0d",
               dis_n, done_i, ramp_i, DISCH_CYC, DISCH_CYC, DISCH_CYC + 1);
    end
    req = 0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_async_reset();
    req = 1; vok = 1;
    for (int i = 0; i < 20 && ready !== 1'b1; i++) step();
    #2;
    RESETB = 1'b0;
    #1;
    checks++;
    if ({cp_en, ready, busy, disch_en, state} !== 7'd0) begin
      failures++;
      $display("FAIL async_reset got=%b want=0", {cp_en, ready, busy, disch_en, state});
    end
    model_reset();
    @(negedge CLK);
    RESETB = 1'b1;
    step();
    checks++;
    if (dut_vec !== exp_vec() || state !== 3'd1 || cp_en !== 1'b1) begin
      failures++;
      $display("FAIL async_restart got=%b want=%b", dut_vec, exp_vec());
    end
    req = 0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) req = ~req;
      if ($urandom_range(0, 5) == 0) vok = ~vok;
      clr_err = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rand_outs i=%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
      if (mp != 3) begin
        checks++;
        if (err_code !== exp_code()) begin
          failures++;
          $display("FAIL rand_code i=%0d got=%0d want=%0d", i, err_code, exp_code());
        end
      end
      checks++;
      if ((cp_en && disch_en) || (ready && !cp_en)) begin
        failures++;
        $display("FAIL rand_invariant i=%0d got=%b%b%b want=no overlap", i, cp_en, disch_en, ready);
      end
    end
    clr_err = 0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ramp_timeout();
    test_rail_drop();
    test_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
